// File: rtl/bg_scanner_if.sv
// ============================================================================
// Module   : bg_scanner_if
// Brief    : Control, ROM and VGA-plot signal bundle for the background scanner.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface bg_scanner_if #(
    parameter int XW   = 8,
    parameter int YW   = 7,
    parameter int AW   = 15,
    parameter int NSRC = 8,
    parameter int SELW = 3,
    parameter int CW   = 3
);
    logic                 start;
    logic                 en;
    logic [SELW-1:0]      sel;
    logic [NSRC*CW-1:0]   rom_data;
    logic [AW-1:0]        rom_addr;
    logic [XW-1:0]        x;
    logic [YW-1:0]        y;
    logic [CW-1:0]        color;
    logic                 plot;
    logic                 busy;
    logic                 frame_done;

    modport master (
        output start, en, sel, rom_data,
        input  rom_addr, x, y, color, plot, busy, frame_done
    );

    modport slave (
        input  start, en, sel, rom_data,
        output rom_addr, x, y, color, plot, busy, frame_done
    );
endinterface

`default_nettype wire

// File: rtl/bg_scanner.sv
// ============================================================================
// Module   : bg_scanner
// Brief    : Raster-order background scanner feeding NSRC ROMs and a VGA plot port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bg_scanner #(
    parameter int WIDTH      = 160,
    parameter int HEIGHT     = 120,
    parameter int XW         = 8,
    parameter int YW         = 7,
    parameter int AW         = 15,
    parameter int NSRC       = 8,
    parameter int SELW       = 3,
    parameter int CW         = 3,
    parameter int ROM_LAT    = 1,
    parameter int CONTINUOUS = 0
) (
    input  logic         CLOCK_50,
    input  logic         resetn,
    bg_scanner_if.slave  bus
);

    // The issue stage (rom_addr register) plus ROM_LAT stages of ROM latency.
    localparam int DEPTH = ROM_LAT + 1;
    localparam int DW    = $clog2(ROM_LAT + 1) + 1;
    localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t            state;
    logic [XW-1:0]     ix;
    logic [YW-1:0]     iy;
    logic [AW-1:0]     addr;
    logic [SELW-1:0]   sel_lat;
    logic [DW-1:0]     drain_cnt;

    logic [DEPTH-1:0]  pipe_v;
    logic [XW-1:0]     pipe_x   [DEPTH];
    logic [YW-1:0]     pipe_y   [DEPTH];
    logic [SELW-1:0]   pipe_sel [DEPTH];

    logic [AW-1:0]     rom_addr_reg;
    logic [XW-1:0]     x_reg;
    logic [YW-1:0]     y_reg;
    logic [CW-1:0]     color_reg;
    logic              plot_reg;
    logic              frame_done_reg;

    logic              issue;
    logic [CW-1:0]     src_color;

    assign issue = (state == SCAN) && bus.en;

    // Out-of-range selectors fall through to colour 0.
    always_comb begin
        src_color = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (int'(pipe_sel[DEPTH-1]) == i) begin
                src_color = bus.rom_data[i*CW +: CW];
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state          <= IDLE;
            ix             <= '0;
            iy             <= '0;
            addr           <= '0;
            sel_lat        <= '0;
            drain_cnt      <= '0;
            pipe_v         <= '0;
            rom_addr_reg   <= '0;
            x_reg          <= '0;
            y_reg          <= '0;
            color_reg      <= '0;
            plot_reg       <= 1'b0;
            frame_done_reg <= 1'b0;
            for (int k = 0; k < DEPTH; k++) begin
                pipe_x[k]   <= '0;
                pipe_y[k]   <= '0;
                pipe_sel[k] <= '0;
            end
        end else begin
            // Every cycle pushes an entry so bubbles stay aligned with ROM data.
            pipe_v      <= {pipe_v[DEPTH-2:0], issue};
            pipe_x[0]   <= ix;
            pipe_y[0]   <= iy;
            pipe_sel[0] <= sel_lat;
            for (int k = 1; k < DEPTH; k++) begin
                pipe_x[k]   <= pipe_x[k-1];
                pipe_y[k]   <= pipe_y[k-1];
                pipe_sel[k] <= pipe_sel[k-1];
            end

            x_reg          <= pipe_x[DEPTH-1];
            y_reg          <= pipe_y[DEPTH-1];
            plot_reg       <= pipe_v[DEPTH-1];
            color_reg      <= src_color;
            frame_done_reg <= pipe_v[DEPTH-1] &&
                              (pipe_x[DEPTH-1] == X_LAST) &&
                              (pipe_y[DEPTH-1] == Y_LAST);

            case (state)
                IDLE: begin
                    if (bus.start) begin
                        sel_lat <= bus.sel;
                        ix      <= '0;
                        iy      <= '0;
                        addr    <= '0;
                        state   <= SCAN;
                    end
                end
                SCAN: begin
                    if (bus.en) begin
                        rom_addr_reg <= addr;
                        addr         <= addr + AW'(1);
                        if (ix == X_LAST) begin
                            ix <= '0;
                            if (iy == Y_LAST) begin
                                iy   <= '0;
                                addr <= '0;
                                if (CONTINUOUS != 0) begin
                                    sel_lat <= bus.sel;
                                end else begin
                                    state     <= DRAIN;
                                    drain_cnt <= '0;
                                end
                            end else begin
                                iy <= iy + YW'(1);
                            end
                        end else begin
                            ix <= ix + XW'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (drain_cnt == DW'(ROM_LAT)) begin
                        state <= IDLE;
                    end else begin
                        drain_cnt <= drain_cnt + DW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.rom_addr   = rom_addr_reg;
    assign bus.x          = x_reg;
    assign bus.y          = y_reg;
    assign bus.color      = color_reg;
    assign bus.plot       = plot_reg;
    assign bus.frame_done = frame_done_reg;
    assign bus.busy       = (state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_bg_scanner.sv
// ============================================================================
// Module   : tb_bg_scanner
// Brief    : One-shot and continuous scanners checked against a pixel-stream model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bg_scanner;

    localparam int W    = 10;
    localparam int H    = 4;
    localparam int N    = W * H;
    localparam int XW   = 4;
    localparam int YW   = 2;
    localparam int AW   = 6;
    localparam int NSRC = 6;
    localparam int SELW = 3;
    localparam int CW   = 3;
    localparam int L    = 2;

    typedef struct {
        bit v;
        int x;
        int y;
        int c;
        bit last;
    } item_t;

    logic            clk = 1'b0;
    logic            resetn;
    logic            start;
    logic            en;
    logic [SELW-1:0] sel;

    int total = 0;
    int bad   = 0;
    int nplot;
    int nfd;

    // Reference model state, index 0 = one-shot DUT, 1 = continuous DUT.
    bit    scanning [2];
    int    p        [2];
    int    sel_cur  [2];
    int    drain    [2];
    int    m_addr   [2];
    item_t dl       [2][L+1];
    item_t ex       [2];

    logic [AW-1:0] la0 [L];
    logic [AW-1:0] la1 [L];

    always #5 clk = ~clk;

    bg_scanner_if #(.XW(XW), .YW(YW), .AW(AW), .NSRC(NSRC), .SELW(SELW), .CW(CW)) bus0 ();
    bg_scanner_if #(.XW(XW), .YW(YW), .AW(AW), .NSRC(NSRC), .SELW(SELW), .CW(CW)) bus1 ();

    bg_scanner #(.WIDTH(W), .HEIGHT(H), .XW(XW), .YW(YW), .AW(AW), .NSRC(NSRC),
                 .SELW(SELW), .CW(CW), .ROM_LAT(L), .CONTINUOUS(0))
        u_os (.CLOCK_50(clk), .resetn(resetn), .bus(bus0));

    bg_scanner #(.WIDTH(W), .HEIGHT(H), .XW(XW), .YW(YW), .AW(AW), .NSRC(NSRC),
                 .SELW(SELW), .CW(CW), .ROM_LAT(L), .CONTINUOUS(1))
        u_ct (.CLOCK_50(clk), .resetn(resetn), .bus(bus1));

    function automatic logic [NSRC*CW-1:0] rom_word(logic [AW-1:0] a);
        logic [NSRC*CW-1:0] w;
        w = '0;
        for (int i = 0; i < NSRC; i++) w[i*CW +: CW] = CW'(a + AW'(3 * i));
        return w;
    endfunction

    function automatic int colour(int pix, int s);
        return (s < NSRC) ? (pix + 3 * s) % 8 : 0;
    endfunction

    function automatic item_t blank();
        item_t b;
        b.v = 0; b.x = 0; b.y = 0; b.c = 0; b.last = 0;
        return b;
    endfunction

    assign bus0.start = start;
    assign bus0.en    = en;
    assign bus0.sel   = sel;
    assign bus1.start = start;
    assign bus1.en    = en;
    assign bus1.sel   = sel;
    assign bus0.rom_data = rom_word(la0[L-1]);
    assign bus1.rom_data = rom_word(la1[L-1]);

    // ROMs with L cycles of read latency.
    always @(posedge clk) begin
        la0[0] <= bus0.rom_addr;
        la1[0] <= bus1.rom_addr;
        for (int k = 1; k < L; k++) begin
            la0[k] <= la0[k-1];
            la1[k] <= la1[k-1];
        end
    end

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance the model by one edge, clock the DUTs, then compare.
    task automatic step();
        item_t it;
        string tag;
        logic [31:0] o_plot, o_fd, o_busy, o_addr, o_x, o_y, o_c;
        for (int d = 0; d < 2; d++) begin
            if (!resetn) begin
                scanning[d] = 0; p[d] = 0; sel_cur[d] = 0; drain[d] = 0; m_addr[d] = 0;
                for (int k = 0; k <= L; k++) dl[d][k] = blank();
                ex[d] = blank();
            end else begin
                ex[d]   = dl[d][L];
                it      = blank();
                it.v    = scanning[d] && en;
                it.x    = p[d] % W;
                it.y    = p[d] / W;
                it.c    = colour(p[d], sel_cur[d]);
                it.last = (p[d] == N - 1);
                if (!scanning[d] && drain[d] == 0 && start) begin
                    scanning[d] = 1; p[d] = 0; sel_cur[d] = int'(sel);
                end else if (scanning[d] && en) begin
                    m_addr[d] = p[d];
                    p[d]++;
                    if (p[d] == N) begin
                        p[d] = 0;
                        if (d == 1) sel_cur[d] = int'(sel);
                        else begin scanning[d] = 0; drain[d] = L + 1; end
                    end
                end else if (drain[d] > 0) begin
                    drain[d]--;
                end
                for (int k = L; k > 0; k--) dl[d][k] = dl[d][k-1];
                dl[d][0] = it;
            end
        end
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            tag    = (d == 0) ? "os_" : "ct_";
            o_plot = (d == 0) ? 32'(bus0.plot)       : 32'(bus1.plot);
            o_fd   = (d == 0) ? 32'(bus0.frame_done) : 32'(bus1.frame_done);
            o_busy = (d == 0) ? 32'(bus0.busy)       : 32'(bus1.busy);
            o_addr = (d == 0) ? 32'(bus0.rom_addr)   : 32'(bus1.rom_addr);
            o_x    = (d == 0) ? 32'(bus0.x)          : 32'(bus1.x);
            o_y    = (d == 0) ? 32'(bus0.y)          : 32'(bus1.y);
            o_c    = (d == 0) ? 32'(bus0.color)      : 32'(bus1.color);
            chk({tag, "plot"},       o_plot, 32'(ex[d].v));
            chk({tag, "frame_done"}, o_fd,   32'(ex[d].v && ex[d].last));
            chk({tag, "busy"},       o_busy, 32'(scanning[d] || drain[d] > 0));
            chk({tag, "rom_addr"},   o_addr, 32'(m_addr[d]));
            if (ex[d].v) begin
                chk({tag, "x"},     o_x, 32'(ex[d].x));
                chk({tag, "y"},     o_y, 32'(ex[d].y));
                chk({tag, "color"}, o_c, 32'(ex[d].c));
            end
            if (!resetn) begin
                chk({tag, "rst_x"},     o_x, 32'd0);
                chk({tag, "rst_y"},     o_y, 32'd0);
                chk({tag, "rst_color"}, o_c, 32'd0);
            end
        end
        if (bus0.plot === 1'b1)       nplot++;
        if (bus0.frame_done === 1'b1) nfd++;
    endtask

    initial begin
        resetn = 1'b0;
        start  = 1'b0;
        en     = 1'b1;
        sel    = 3'd2;
        repeat (3) step();
        resetn = 1'b1;
        step();

        // Uninterrupted one-shot frame from source 2; continuous DUT also starts.
        nplot = 0; nfd = 0;
        start = 1'b1; step(); start = 1'b0;
        repeat (N + L + 4) step();
        chk("os_frame_plots", 32'(nplot), 32'(N));
        chk("os_frame_done_count", 32'(nfd), 32'd1);
        chk("os_idle_after", 32'(bus0.busy), 32'd0);

        // Alternating en: one bubble per paused cycle.
        nplot = 0; nfd = 0;
        start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < 2 * N + L + 6; i++) begin
            en = (i % 2) == 1;
            step();
        end
        en = 1'b1;
        chk("toggle_plots", 32'(nplot), 32'(N));
        chk("toggle_frame_done", 32'(nfd), 32'd1);

        // Random pauses with a mid-frame scene change.
        nplot = 0; nfd = 0;
        start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < 3 * N; i++) begin
            en = ($urandom % 4) != 0;
            if (i == N / 2) sel = 3'd4;
            if (i > N && ($urandom % 16) == 0) sel = SELW'($urandom % 6);
            step();
        end
        en = 1'b1;
        repeat (N + L + 4) step();
        chk("random_plots", 32'(nplot), 32'(N));

        // Selector beyond NSRC yields colour 0.
        sel = 3'd7;
        nplot = 0; nfd = 0;
        start = 1'b1; step(); start = 1'b0;
        repeat (2 * N + L + 4) step();
        chk("sel7_plots", 32'(nplot), 32'(N));

        // Reset in mid-frame, then a clean restart.
        sel = 3'd3;
        start = 1'b1; step(); start = 1'b0;
        repeat (15) step();
        resetn = 1'b0;
        repeat (3) step();
        resetn = 1'b1;
        step();
        nplot = 0; nfd = 0;
        start = 1'b1; step(); start = 1'b0;
        repeat (N + L + 4) step();
        chk("restart_plots", 32'(nplot), 32'(N));
        chk("restart_frame_done", 32'(nfd), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
